// File: rtl/rnn_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rnn_frame_sequencer
// Brief    : Runs the denoiser layer engines one at a time per feature frame
//            using start/done handshakes. Registers the input frame and the
//            result, supports a VAD-gated early exit, a per-stage watchdog
//            and a GRU state-clear request.
// Revision : 1.0 - initial release
// ============================================================================
module rnn_frame_sequencer #(
   parameter int               FLOAT       = 32,
   parameter int               INPUT_SIZE  = 42,
   parameter int               OUTPUT_SIZE = 22,
   parameter int               NUM_STAGES  = 6,
   parameter int               VAD_STAGE   = 2,
   parameter logic [FLOAT-1:0] VAD_THRESH  = 32'h3DCCCCCD,
   parameter int               TIMEOUT     = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [INPUT_SIZE*FLOAT-1:0]   in_feature,
   output logic [INPUT_SIZE*FLOAT-1:0]   feature_q,
   output logic [NUM_STAGES-1:0]         stage_start,
   input  logic [NUM_STAGES-1:0]         stage_done,
   input  logic [FLOAT-1:0]              vad_in,
   input  logic [OUTPUT_SIZE*FLOAT-1:0]  gains_in,
   input  logic                          skip_en,
   input  logic                          clear_req,
   output logic                          state_clear,
   input  logic                          clr_err,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUTPUT_SIZE*FLOAT-1:0]  out_gains,
   output logic [FLOAT-1:0]              out_vad,
   output logic [15:0]                   frame_cnt,
   output logic                          error,
   output logic                          busy
);

   localparam int c_IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int c_WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [c_IDX_W-1:0] c_VAD_IDX  = c_IDX_W'(VAD_STAGE);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_STAGES - 1);
   localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;
   logic [c_IDX_W-1:0]   r_idx;
   logic [c_WD_W-1:0]    r_wdog;
   logic                 r_clear_pend;
   logic                 w_accept;
   logic                 w_done;
   logic                 w_skip;
   logic                 w_timeout;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state decode and handshake/pulse outputs
   always_comb begin
      w_state_nx  = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      stage_start = '0;
      state_clear = 1'b0;
      busy        = (r_state != S_IDLE);
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_skip      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A pending clear takes priority over a new frame; in_ready is
            // held low while rst_n is asserted.
            in_ready = rst_n & ~r_clear_pend;
            if (r_clear_pend) begin
               w_state_nx = S_CLEAR;
            end else if (in_valid && in_ready) begin
               w_accept   = 1'b1;
               w_state_nx = S_START;
            end
         end
         S_CLEAR: begin
            state_clear = 1'b1;
            w_state_nx  = S_IDLE;
         end
         S_START: begin
            stage_start[r_idx] = 1'b1;
            w_state_nx         = S_WAIT;
         end
         S_WAIT: begin
            // Only the running engine's done bit is honoured.
            w_done = stage_done[r_idx];
            if (w_done) begin
               if ((r_idx == c_VAD_IDX) && skip_en && (vad_in < VAD_THRESH)) begin
                  w_skip     = 1'b1;
                  w_state_nx = S_OUT;
               end else if (r_idx == c_LAST_IDX) begin
                  w_state_nx = S_OUT;
               end else begin
                  w_state_nx = S_START;
               end
            end else if (r_wdog == c_WD_LAST) begin
               // Last allowed WAIT cycle passed without done: drop the frame
               // and reset the GRU states through the CLEAR pulse.
               w_timeout  = 1'b1;
               w_state_nx = S_CLEAR;
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Frame datapath, stage index, watchdog, counters and sticky flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         feature_q    <= '0;
         out_gains    <= '0;
         out_vad      <= '0;
         frame_cnt    <= '0;
         error        <= 1'b0;
         r_idx        <= '0;
         r_wdog       <= '0;
         r_clear_pend <= 1'b0;
      end else begin
         if (w_accept) begin
            feature_q <= in_feature;
            r_idx     <= '0;
         end
         if (r_state == S_START) begin
            r_wdog <= '0;
         end else if ((r_state == S_WAIT) && !w_done) begin
            r_wdog <= r_wdog + c_WD_W'(1);
         end
         if (w_done) begin
            if (r_idx == c_VAD_IDX) begin
               out_vad <= vad_in;
            end
            if (w_skip) begin
               out_gains <= '0;
            end else if (r_idx == c_LAST_IDX) begin
               out_gains <= gains_in;
            end else begin
               r_idx <= r_idx + c_IDX_W'(1);
            end
         end
         if (out_valid && out_ready) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         // Timeout has priority over a simultaneous clear.
         if (w_timeout) begin
            error <= 1'b1;
         end else if (clr_err) begin
            error <= 1'b0;
         end
         // A new request wins over the consumption in CLEAR.
         r_clear_pend <= (r_clear_pend && (r_state != S_CLEAR)) || clear_req;
      end
   end

endmodule
`default_nettype wire
